// File: rtl/lab1_vector_sequencer_pkg.sv
// Shared types and constants for the Lab1 F(A,B,C,D) vector sequencer.
package lab1_vector_sequencer_pkg;
  localparam int VEC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/lab1_hold_timer.sv
// Per-vector hold timer: counts 0..HOLD_CYCLES-1 while enabled, tick on the last count.
module lab1_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= tick ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/lab1_vector_sequencer.sv
// Exhaustive stimulus sweep for F(A,B,C,D): drives each vector for HOLD_CYCLES,
// compares the three implementation outputs on the last hold cycle and logs disagreements.
module lab1_vector_sequencer
  import lab1_vector_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int NUM_VEC     = 16,
  parameter int ERR_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             f1,
  input  logic             f2,
  input  logic             f3,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] vec_idx,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [VEC_W-1:0] first_err_vec
);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  state_t state;
  logic   tick, start_ok, f_diff;

  assign start_ok     = start && (state != ST_DRIVE);
  assign f_diff       = (f1 != f2) | (f2 != f3);
  assign {a, b, c, d} = vec_idx;

  lab1_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start_ok),
    .en   (state == ST_DRIVE),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      vec_idx         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      mismatch        <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state           <= ST_DRIVE;
            vec_idx         <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
          end
        end
        ST_DRIVE: begin
          if (tick) begin
            mismatch <= f_diff;
            if (f_diff) begin
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_vec   <= vec_idx;
              end
            end
            // The final vector stays on a..d for readout instead of wrapping.
            if (vec_idx == LAST_VEC) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec_idx <= vec_idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lab1_vector_sequencer.sv
// Randomized sweeps against a timing-arithmetic model of the sequencer, plus literal checks.
module tb_lab1_vector_sequencer;
  localparam int H     = 4;
  localparam int NV    = 16;
  localparam int EW    = 3;
  localparam int SWEEP = H * NV;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic a, b, c, d, f1, f2, f3, busy, done, mismatch, first_err_valid;
  logic [3:0] vec_idx, first_err_vec;
  logic [EW-1:0] err_cnt;

  logic [2:0] mask  [16];
  logic [2:0] smask [16];

  int n_chk = 0, n_fail = 0;

  lab1_vector_sequencer #(.HOLD_CYCLES(H), .NUM_VEC(NV), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .c(c), .d(d), .f1(f1), .f2(f2), .f3(f3),
    .busy(busy), .done(done), .vec_idx(vec_idx), .mismatch(mismatch),
    .err_cnt(err_cnt), .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
  );

  always #5 clk = ~clk;

  function automatic logic golden(input logic [3:0] v);
    return (v[3] & v[2]) | (~v[1] & v[0]);
  endfunction

  // Implementations under test: golden F with a per-vector inversion mask.
  assign {f1, f2, f3} = {3{golden({a, b, c, d})}} ^ mask[{a, b, c, d}];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit mm(input int j);
    logic [2:0] fv;
    fv = {3{golden(4'(j))}} ^ smask[j];
    return !(fv == 3'b000 || fv == 3'b111);
  endfunction

  // Model: a sweep is just "edges elapsed since the accepted start".
  int edge_n = 0, t0 = 0;
  bit running = 0, inited = 0;

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      running = 0;
      inited  = 1;
    end else if (start && (!running || edge_n - t0 > SWEEP)) begin
      running = 1;
      t0      = edge_n;
      for (int i = 0; i < 16; i++) smask[i] = mask[i];
    end
  end

  always @(negedge clk) begin
    if (inited) begin
      int n, k, e_vec, e_busy, e_done, e_mis, errs, e_fv, e_fvec;
      e_vec = 0; e_busy = 0; e_done = 0; e_mis = 0; errs = 0; e_fv = 0; e_fvec = 0; k = 0;
      if (running) begin
        n = edge_n - t0;
        if (n >= SWEEP) begin
          k = NV; e_vec = NV - 1; e_done = 1;
          e_mis = (n == SWEEP) ? int'(mm(NV - 1)) : 0;
        end else begin
          k = n / H; e_vec = k; e_busy = 1;
          e_mis = (n > 0 && n % H == 0) ? int'(mm(k - 1)) : 0;
        end
        for (int j = 0; j < k; j++) begin
          if (mm(j)) begin
            if (!e_fv) begin e_fv = 1; e_fvec = j; end
            errs++;
          end
        end
      end
      if (errs > (1 << EW) - 1) errs = (1 << EW) - 1;
      chk("vec_idx", vec_idx, e_vec);
      chk("abcd", {a, b, c, d}, e_vec);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("mismatch", mismatch, e_mis);
      chk("err_cnt", err_cnt, errs);
      chk("first_err_valid", first_err_valid, e_fv);
      chk("first_err_vec", first_err_vec, e_fvec);
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Runs until done (bounded); optionally re-pulses start when vec_idx hits repulse_at.
  task automatic run_sweep(input int repulse_at, output int cyc, output int pulses);
    bit rp = 0;
    cyc = 0; pulses = 0;
    while (!done && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      pulses += int'(mismatch);
      if (!rp && !done && int'(vec_idx) == repulse_at) begin start = 1'b1; rp = 1; end
    end
    start = 1'b0;
    if (!done) chk("sweep_timeout", cyc, SWEEP);
  endtask

  task automatic wait_vec(input int v);
    int t = 0;
    while (int'(vec_idx) != v && t < 200) begin @(posedge clk); #1; t++; end
    if (int'(vec_idx) != v) chk("wait_vec_timeout", vec_idx, v);
  endtask

  initial begin
    int cyc, pulses;
    for (int i = 0; i < 16; i++) mask[i] = 3'b000;

    // Reset held for three edges
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_abcd", {a, b, c, d}, 0);

    // Clean sweep
    pulse_start();
    run_sweep(99, cyc, pulses);
    chk("clean_latency", cyc, 64);
    chk("clean_err_cnt", err_cnt, 0);
    chk("clean_first_valid", first_err_valid, 0);
    chk("clean_pulses", pulses, 0);

    // f3 wrong only on vector 5
    mask[5] = 3'b001;
    pulse_start();
    run_sweep(99, cyc, pulses);
    chk("v5_err_cnt", err_cnt, 1);
    chk("v5_first_vec", first_err_vec, 5);
    chk("v5_first_valid", first_err_valid, 1);
    chk("v5_pulses", pulses, 1);
    mask[5] = 3'b000;

    // Restart from DONE clears readout; re-pulse in DRIVE is ignored
    pulse_start();
    chk("restart_err_cnt", err_cnt, 0);
    chk("restart_done", done, 0);
    chk("restart_vec", vec_idx, 0);
    run_sweep(3, cyc, pulses);
    chk("repulse_latency", cyc, 64);

    // Reset mid-sweep at vector 7
    pulse_start();
    wait_vec(7);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_abcd", {a, b, c, d}, 0);

    // f1 always wrong: counter saturates
    for (int i = 0; i < 16; i++) mask[i] = 3'b100;
    pulse_start();
    run_sweep(99, cyc, pulses);
    chk("sat_err_cnt", err_cnt, 7);
    chk("sat_first_vec", first_err_vec, 0);
    chk("sat_pulses", pulses, 16);

    // Randomized fault patterns and stray start pulses
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 16; i++)
        mask[i] = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      pulse_start();
      run_sweep($urandom_range(0, 24), cyc, pulses);
      chk("rand_latency", cyc, 64);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
